// File: rtl/rv_mem_pkg.sv
// Shared memory-op encodings and the byte-strobe helper used by the store buffer.
package rv_mem_pkg;

  localparam logic [6:0] STORE_OP = 7'b0100011;

  // Store funct3
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Load funct3 (LB/LH/LW share encodings with SB/SH/SW)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Byte strobe for an access of the given funct3 at byte offset off.
  // Unsigned loads touch the same bytes as their signed forms; unknown codes touch nothing.
  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] m;
    case (funct3)
      F3_SB, F3_LBU: m = 4'b0001 << off;
      F3_SH, F3_LHU: m = 4'b0011 << off;
      F3_SW:         m = 4'b1111;
      default:       m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational store formatter: funct3 + byte address + right-aligned data
// -> byte strobes, lane-replicated write data and a misalignment/illegal flag.
module store_lane_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  st_type_i,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  strb_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  // Replicate data across lanes so the strobe alone selects the bytes written.
  always_comb begin
    strb_o       = byte_mask(st_type_i, st_addr_i[1:0]);
    wdata_o      = '0;
    misaligned_o = 1'b0;
    case (st_type_i)
      F3_SB: wdata_o = {4{st_data_i[7:0]}};
      F3_SH: begin
        wdata_o      = {2{st_data_i[15:0]}};
        misaligned_o = st_addr_i[0];
      end
      F3_SW: begin
        wdata_o      = st_data_i;
        misaligned_o = (st_addr_i[1:0] != 2'b00);
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_commit_buffer.sv
// Post-commit store queue: accepts retired stores, holds them in order and
// drains them to memory over req/ack; also flags loads overlapping pending stores.
module store_commit_buffer
  import rv_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_valid,
  input  logic [31:0]      commit_addr,
  input  logic [31:0]      commit_data,
  input  logic [2:0]       commit_type,
  output logic             commit_ready,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ack,
  input  logic [31:0]      ld_addr,
  input  logic [2:0]       ld_type,
  output logic             ld_conflict,
  output logic             misalign_err,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [29:0]      slot_addr_q [DEPTH];
  logic [29:0]      slot_addr_d [DEPTH];
  logic [31:0]      slot_data_q [DEPTH];
  logic [31:0]      slot_data_d [DEPTH];
  logic [3:0]       slot_strb_q [DEPTH];
  logic [3:0]       slot_strb_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misalign_q, misalign_d;

  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic        st_misaligned;
  logic        accept;
  logic        enq;
  logic        pop;
  logic [3:0]  ld_strb;

  store_lane_align u_align (
    .st_type_i    (commit_type),
    .st_addr_i    (commit_addr),
    .st_data_i    (commit_data),
    .strb_o       (st_strb),
    .wdata_o      (st_wdata),
    .misaligned_o (st_misaligned)
  );

  // Handshake decode; a rejected store still consumes the commit slot.
  always_comb begin
    commit_ready = (count_q != CNT_W'(DEPTH));
    empty        = (count_q == '0);
    mem_req      = !empty;
    accept       = commit_valid && commit_ready;
    enq          = accept && !st_misaligned;
    pop          = mem_req && mem_ack;
    count        = count_q;
    misalign_err = misalign_q;
  end

  // Head entry drives the memory port; zeroed while nothing is pending.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (mem_req) begin
      mem_addr  = {slot_addr_q[head_q], 2'b00};
      mem_wdata = slot_data_q[head_q];
      mem_wstrb = slot_strb_q[head_q];
    end
  end

  // Queue next state: pop clears head, enqueue fills tail, count tracks the net change.
  always_comb begin
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    slot_strb_d = slot_strb_q;
    valid_d     = valid_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    misalign_d  = accept && st_misaligned;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (enq) begin
      valid_d[tail_q]     = 1'b1;
      slot_addr_d[tail_q] = commit_addr[31:2];
      slot_data_d[tail_q] = st_wdata;
      slot_strb_d[tail_q] = st_strb;
      tail_d              = tail_q + 1'b1;
    end
    case ({enq, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every pending store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_addr_q <= '{default: '0};
      slot_data_q <= '{default: '0};
      slot_strb_q <= '{default: '0};
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      misalign_q  <= 1'b0;
    end else begin
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
      slot_strb_q <= slot_strb_d;
      valid_q     <= valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      misalign_q  <= misalign_d;
    end
  end

  assign ld_strb = byte_mask(ld_type, ld_addr[1:0]);

  // Any valid entry in the same word sharing a byte with the load is a conflict,
  // including the head entry being popped this cycle.
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (slot_addr_q[i] == ld_addr[31:2]) &&
          ((slot_strb_q[i] & ld_strb) != 4'b0000)) begin
        ld_conflict = 1'b1;
      end
    end
  end

endmodule
